// File: rtl/generic_bus_rr_arbiter_pkg.sv
// Bus-bridge types: arbiter state encoding.
package generic_bus_rr_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE,
    SERVE0,
    SERVE1
  } arb_state_t;
endpackage

// File: rtl/rv32i_types_pkg.sv
// Core-wide RV32I types shared by the bus and memory blocks.
package rv32i_types_pkg;
  localparam int unsigned RAM_ADDR_SIZE = 32;
  localparam int unsigned WORD_SIZE     = 32;

  typedef logic [WORD_SIZE-1:0] word_t;
endpackage

// File: rtl/generic_bus_rr_arbiter_if.sv
// Generic RAM-style bus: generic_bus is the memory side, cpu is the master side.
interface generic_bus_if;
  import rv32i_types_pkg::*;

  logic [RAM_ADDR_SIZE-1:0] addr;
  word_t                    wdata;
  word_t                    rdata;
  logic                     ren;
  logic                     wen;
  logic                     busy;
  logic [3:0]               byte_en;

  modport generic_bus (
    input  addr, ren, wen, wdata, byte_en,
    output rdata, busy
  );

  modport cpu (
    output addr, ren, wen, wdata, byte_en,
    input  rdata, busy
  );
endinterface

// File: rtl/generic_bus_rr_arbiter.sv
// Two-requester arbiter sharing one generic_bus RAM port; grant is held until
// the downstream busy deasserts, and over-long transactions raise timeout_err.
module generic_bus_rr_arbiter
  import generic_bus_rr_arbiter_pkg::*;
#(
  parameter bit          FIXED_PRIORITY = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic               CLK,
  input  logic               nRST,
  generic_bus_if.generic_bus req0_bus_if,
  generic_bus_if.generic_bus req1_bus_if,
  generic_bus_if.cpu         out_bus_if,
  output logic [1:0]         grant,
  output logic               timeout_err
);

  localparam int unsigned TMO_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

  arb_state_t       state;
  arb_state_t       next_state;
  logic             last_served;
  logic             bubble;
  logic [TMO_W-1:0] tmo_cnt;
  logic [TMO_W-1:0] tmo_inc;
  logic             req0;
  logic             req1;

  assign req0 = req0_bus_if.ren | req0_bus_if.wen;
  assign req1 = req1_bus_if.ren | req1_bus_if.wen;

  always_comb begin
    tmo_inc = (tmo_cnt == '1) ? tmo_cnt : tmo_cnt + 1'b1;
  end

  always_comb begin
    next_state          = state;
    grant               = '0;
    out_bus_if.addr     = '0;
    out_bus_if.ren      = 1'b0;
    out_bus_if.wen      = 1'b0;
    out_bus_if.wdata    = '0;
    out_bus_if.byte_en  = '0;
    req0_bus_if.busy    = 1'b1;
    req1_bus_if.busy    = 1'b1;
    req0_bus_if.rdata   = out_bus_if.rdata;
    req1_bus_if.rdata   = out_bus_if.rdata;

    case (state)
      IDLE: begin
        // The post-transaction bubble cycle does not arbitrate.
        if (!bubble) begin
          if (req0 && req1)
            next_state = (FIXED_PRIORITY || last_served) ? SERVE0 : SERVE1;
          else if (req0)
            next_state = SERVE0;
          else if (req1)
            next_state = SERVE1;
        end
      end
      SERVE0: begin
        grant              = 2'b01;
        out_bus_if.addr    = req0_bus_if.addr;
        out_bus_if.ren     = req0_bus_if.ren;
        out_bus_if.wen     = req0_bus_if.wen;
        out_bus_if.wdata   = req0_bus_if.wdata;
        out_bus_if.byte_en = req0_bus_if.byte_en;
        req0_bus_if.busy   = out_bus_if.busy;
        if (!out_bus_if.busy || !req0)
          next_state = IDLE;
      end
      SERVE1: begin
        grant              = 2'b10;
        out_bus_if.addr    = req1_bus_if.addr;
        out_bus_if.ren     = req1_bus_if.ren;
        out_bus_if.wen     = req1_bus_if.wen;
        out_bus_if.wdata   = req1_bus_if.wdata;
        out_bus_if.byte_en = req1_bus_if.byte_en;
        req1_bus_if.busy   = out_bus_if.busy;
        if (!out_bus_if.busy || !req1)
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      last_served <= 1'b1;
      bubble      <= 1'b0;
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      state  <= next_state;
      bubble <= (state != IDLE);
      if (state == IDLE) begin
        tmo_cnt <= '0;
      end else if (out_bus_if.busy) begin
        // An abort also lands here (busy still high), so last_served is kept.
        tmo_cnt <= tmo_inc;
        if (TIMEOUT_CYCLES != 0 && tmo_inc == TMO_LIMIT)
          timeout_err <= 1'b1;
      end else begin
        last_served <= (state == SERVE1);
      end
    end
  end

endmodule

// File: tb/tb_generic_bus_rr_arbiter.sv
// Directed self-checking bench: round-robin/timeout instance plus fixed-priority instance.
module tb_generic_bus_rr_arbiter;
  logic        CLK;
  logic        nRST;
  logic [1:0]  grant_a;
  logic [1:0]  grant_b;
  logic        tmo_a;
  logic        tmo_b;
  int unsigned pass_cnt;
  int unsigned total_cnt;

  logic [1:0] rr_exp [12] = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00,
                              2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};

  generic_bus_if r0a ();
  generic_bus_if r1a ();
  generic_bus_if oa  ();
  generic_bus_if r0b ();
  generic_bus_if r1b ();
  generic_bus_if ob  ();

  generic_bus_rr_arbiter #(.FIXED_PRIORITY(1'b0), .TIMEOUT_CYCLES(8)) dut_rr (
    .CLK(CLK), .nRST(nRST),
    .req0_bus_if(r0a), .req1_bus_if(r1a), .out_bus_if(oa),
    .grant(grant_a), .timeout_err(tmo_a)
  );

  generic_bus_rr_arbiter #(.FIXED_PRIORITY(1'b1), .TIMEOUT_CYCLES(1024)) dut_fp (
    .CLK(CLK), .nRST(nRST),
    .req0_bus_if(r0b), .req1_bus_if(r1b), .out_bus_if(ob),
    .grant(grant_b), .timeout_err(tmo_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic clear_reqs;
    r0a.ren = 0; r0a.wen = 0; r0a.addr = '0; r0a.wdata = '0; r0a.byte_en = '0;
    r1a.ren = 0; r1a.wen = 0; r1a.addr = '0; r1a.wdata = '0; r1a.byte_en = '0;
    r0b.ren = 0; r0b.wen = 0; r0b.addr = '0; r0b.wdata = '0; r0b.byte_en = '0;
    r1b.ren = 0; r1b.wen = 0; r1b.addr = '0; r1b.wdata = '0; r1b.byte_en = '0;
  endtask

  task automatic go_idle;
    clear_reqs();
    repeat (3) tick();
  endtask

  task automatic test_reset;
    nRST = 1'b0;
    clear_reqs();
    oa.busy = 1'b1; oa.rdata = '0;
    ob.busy = 1'b0; ob.rdata = '0;
    r0a.ren = 1'b1; r1a.ren = 1'b1;
    repeat (2) tick();
    settle();
    total_cnt++; if (oa.ren !== 1'b0) $display("FAIL rst_out_ren: got %b exp 0", oa.ren); else pass_cnt++;
    total_cnt++; if (r0a.busy !== 1'b1) $display("FAIL rst_busy0: got %b exp 1", r0a.busy); else pass_cnt++;
    total_cnt++; if (r1a.busy !== 1'b1) $display("FAIL rst_busy1: got %b exp 1", r1a.busy); else pass_cnt++;
    total_cnt++; if (grant_a !== 2'b00) $display("FAIL rst_grant: got %b exp 00", grant_a); else pass_cnt++;
    total_cnt++; if (tmo_a !== 1'b0) $display("FAIL rst_tmo: got %b exp 0", tmo_a); else pass_cnt++;
    nRST = 1'b1;
    tick();
    total_cnt++; if (grant_a !== 2'b01) $display("FAIL rst_release_grant: got %b exp 01", grant_a); else pass_cnt++;
    total_cnt++; if (oa.ren !== 1'b1) $display("FAIL rst_release_ren: got %b exp 1", oa.ren); else pass_cnt++;
    go_idle();
  endtask

  task automatic test_single_read;
    r1a.ren = 1'b1; r1a.addr = 32'h100;
    settle();
    total_cnt++; if (grant_a !== 2'b00) $display("FAIL sr_arb_grant: got %b exp 00", grant_a); else pass_cnt++;
    tick();
    total_cnt++; if (oa.addr !== 32'h100) $display("FAIL sr_addr: got %h exp 00000100", oa.addr); else pass_cnt++;
    total_cnt++; if (oa.ren !== 1'b1) $display("FAIL sr_ren: got %b exp 1", oa.ren); else pass_cnt++;
    total_cnt++; if (grant_a !== 2'b10) $display("FAIL sr_grant: got %b exp 10", grant_a); else pass_cnt++;
    total_cnt++; if (r1a.busy !== 1'b1) $display("FAIL sr_busy1_wait0: got %b exp 1", r1a.busy); else pass_cnt++;
    total_cnt++; if (r0a.busy !== 1'b1) $display("FAIL sr_busy0_a: got %b exp 1", r0a.busy); else pass_cnt++;
    tick();
    total_cnt++; if (r1a.busy !== 1'b1) $display("FAIL sr_busy1_wait1: got %b exp 1", r1a.busy); else pass_cnt++;
    tick();
    oa.busy = 1'b0; oa.rdata = 32'hDEADBEEF;
    settle();
    total_cnt++; if (r1a.busy !== 1'b0) $display("FAIL sr_done_busy: got %b exp 0", r1a.busy); else pass_cnt++;
    total_cnt++; if (r1a.rdata !== 32'hDEADBEEF) $display("FAIL sr_rdata: got %h exp deadbeef", r1a.rdata); else pass_cnt++;
    total_cnt++; if (r0a.busy !== 1'b1) $display("FAIL sr_busy0_b: got %b exp 1", r0a.busy); else pass_cnt++;
    tick();
    r1a.ren = 1'b0; oa.busy = 1'b1;
    settle();
    total_cnt++; if (grant_a !== 2'b00) $display("FAIL sr_idle_grant: got %b exp 00", grant_a); else pass_cnt++;
    total_cnt++; if (oa.ren !== 1'b0) $display("FAIL sr_idle_ren: got %b exp 0", oa.ren); else pass_cnt++;
  endtask

  task automatic test_round_robin;
    go_idle();
    oa.busy = 1'b0;
    r0a.ren = 1'b1; r0a.addr = 32'h10;
    r1a.ren = 1'b1; r1a.addr = 32'h20;
    for (int n = 0; n < 12; n++) begin
      tick();
      total_cnt++;
      if (grant_a !== rr_exp[n]) $display("FAIL rr_grant[%0d]: got %b exp %b", n, grant_a, rr_exp[n]);
      else pass_cnt++;
      total_cnt++;
      if ({r0a.busy, r1a.busy} !== {rr_exp[n] != 2'b01, rr_exp[n] != 2'b10})
        $display("FAIL rr_busy[%0d]: got %b%b exp %b%b", n, r0a.busy, r1a.busy,
                 rr_exp[n] != 2'b01, rr_exp[n] != 2'b10);
      else pass_cnt++;
    end
    go_idle();
    oa.busy = 1'b1;
  endtask

  task automatic test_fixed_priority;
    ob.busy = 1'b0;
    r0b.ren = 1'b1; r0b.addr = 32'h40;
    r1b.ren = 1'b1; r1b.addr = 32'h50;
    for (int n = 1; n <= 9; n++) begin
      tick();
      total_cnt++;
      if (grant_b !== ((n % 3 == 1) ? 2'b01 : 2'b00))
        $display("FAIL fp_grant[%0d]: got %b exp %b", n, grant_b, (n % 3 == 1) ? 2'b01 : 2'b00);
      else pass_cnt++;
      total_cnt++; if (r1b.busy !== 1'b1) $display("FAIL fp_busy1[%0d]: got %b exp 1", n, r1b.busy); else pass_cnt++;
    end
    r0b.ren = 1'b0;
    tick();
    total_cnt++; if (grant_b !== 2'b10) $display("FAIL fp_req1_after_drop: got %b exp 10", grant_b); else pass_cnt++;
    go_idle();
  endtask

  task automatic test_write_passthrough;
    go_idle();
    r0a.wen = 1'b1; r0a.addr = 32'h200; r0a.wdata = 32'hA5A5A5A5; r0a.byte_en = 4'b0011;
    tick();
    total_cnt++; if (oa.wen !== 1'b1) $display("FAIL wr_wen: got %b exp 1", oa.wen); else pass_cnt++;
    total_cnt++; if (oa.ren !== 1'b0) $display("FAIL wr_ren: got %b exp 0", oa.ren); else pass_cnt++;
    total_cnt++; if (oa.wdata !== 32'hA5A5A5A5) $display("FAIL wr_wdata: got %h exp a5a5a5a5", oa.wdata); else pass_cnt++;
    total_cnt++; if (oa.byte_en !== 4'b0011) $display("FAIL wr_byte_en: got %b exp 0011", oa.byte_en); else pass_cnt++;
    total_cnt++; if (oa.addr !== 32'h200) $display("FAIL wr_addr: got %h exp 00000200", oa.addr); else pass_cnt++;
    total_cnt++; if (grant_a !== 2'b01) $display("FAIL wr_grant: got %b exp 01", grant_a); else pass_cnt++;
    oa.busy = 1'b0;
    settle();
    total_cnt++; if (r0a.busy !== 1'b0) $display("FAIL wr_done_busy: got %b exp 0", r0a.busy); else pass_cnt++;
    tick();
    clear_reqs(); oa.busy = 1'b1;
    settle();
    total_cnt++; if (grant_a !== 2'b00) $display("FAIL wr_idle_grant: got %b exp 00", grant_a); else pass_cnt++;
  endtask

  task automatic test_timeout_abort;
    go_idle();
    total_cnt++; if (tmo_a !== 1'b0) $display("FAIL tmo_initial: got %b exp 0", tmo_a); else pass_cnt++;
    r0a.ren = 1'b1; r0a.addr = 32'h300;
    tick();
    repeat (7) tick();
    total_cnt++; if (tmo_a !== 1'b0) $display("FAIL tmo_after7: got %b exp 0", tmo_a); else pass_cnt++;
    tick();
    total_cnt++; if (tmo_a !== 1'b1) $display("FAIL tmo_after8: got %b exp 1", tmo_a); else pass_cnt++;
    repeat (11) tick();
    total_cnt++; if (tmo_a !== 1'b1) $display("FAIL tmo_sticky: got %b exp 1", tmo_a); else pass_cnt++;
    total_cnt++; if (grant_a !== 2'b01) $display("FAIL tmo_no_abort: got %b exp 01", grant_a); else pass_cnt++;
    r0a.ren = 1'b0;
    tick();
    total_cnt++; if (grant_a !== 2'b00) $display("FAIL abort_grant: got %b exp 00", grant_a); else pass_cnt++;
    total_cnt++; if (oa.ren !== 1'b0) $display("FAIL abort_ren: got %b exp 0", oa.ren); else pass_cnt++;
    total_cnt++; if (tmo_a !== 1'b1) $display("FAIL abort_tmo_kept: got %b exp 1", tmo_a); else pass_cnt++;
    tick();
    r1a.ren = 1'b1; r1a.addr = 32'h400;
    tick();
    total_cnt++; if (grant_a !== 2'b10) $display("FAIL midrst_pre_grant: got %b exp 10", grant_a); else pass_cnt++;
    #2 nRST = 1'b0;
    settle();
    total_cnt++; if (grant_a !== 2'b00) $display("FAIL midrst_grant: got %b exp 00", grant_a); else pass_cnt++;
    total_cnt++; if (oa.ren !== 1'b0) $display("FAIL midrst_ren: got %b exp 0", oa.ren); else pass_cnt++;
    total_cnt++; if (r1a.busy !== 1'b1) $display("FAIL midrst_busy1: got %b exp 1", r1a.busy); else pass_cnt++;
    total_cnt++; if (tmo_a !== 1'b0) $display("FAIL midrst_tmo: got %b exp 0", tmo_a); else pass_cnt++;
    clear_reqs();
    tick();
    nRST = 1'b1;
    tick();
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_fixed_priority();
    test_write_passthrough();
    test_timeout_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
